// File: rtl/ram_readout_ctrl_pkg.sv
// Shared state encodings for the BRAM write-side fill FSM and the read-side dump FSM.
package ram_readout_ctrl_pkg;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_READ  = 3'd1,
    RD_LATCH = 3'd2,
    RD_OUT   = 3'd3,
    RD_DONE  = 3'd4
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_FULL = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ram_readout_ctrl_addr_counter.sv
// Saturating BRAM address counter with clear and terminal-count flag; shared by read and write sides.
module addr_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  logic [ADDR_W-1:0] count_reg;

  // Saturates at the last address so a finished pass never wraps into a new one.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else if (i_clr) begin
      count_reg <= '0;
    end else if (i_en && !o_tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_count = count_reg;
  assign o_tc    = &count_reg;

endmodule

// File: rtl/ram_readout_ctrl.sv
// Dumps the whole BRAM word by word to a valid/ready consumer once the write side reports full.
module ram_readout_ctrl
  import ram_readout_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_rd_ena,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  rd_state_e         state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              rd_ena_reg, rd_ena_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [ADDR_W-1:0] cnt_value;

  addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_count (cnt_value),
    .o_tc    (cnt_tc)
  );

  // Outputs are computed for the state being entered so they appear registered with it.
  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    rd_ena_next = 1'b0;
    valid_next  = 1'b0;
    done_next   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_reg)
      RD_IDLE: begin
        cnt_clr = 1'b1;
        if (i_start) begin
          state_next  = RD_READ;
          rd_ena_next = 1'b1;
        end
      end
      RD_READ: begin
        state_next = RD_LATCH;
      end
      RD_LATCH: begin
        data_next  = i_rd_data;
        valid_next = 1'b1;
        state_next = RD_OUT;
      end
      RD_OUT: begin
        if (i_ready) begin
          if (cnt_tc) begin
            state_next = RD_DONE;
            done_next  = 1'b1;
          end else begin
            state_next  = RD_READ;
            rd_ena_next = 1'b1;
            cnt_en      = 1'b1;
          end
        end else begin
          valid_next = 1'b1;
        end
      end
      RD_DONE: begin
        // Waiting for start to fall keeps a held full flag from retriggering.
        if (!i_start) begin
          state_next = RD_IDLE;
        end
      end
      default: begin
        state_next = RD_IDLE;
        data_next  = '0;
        cnt_clr    = 1'b1;
      end
    endcase
    busy_next = (state_next != RD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg  <= RD_IDLE;
      data_reg   <= '0;
      rd_ena_reg <= 1'b0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      rd_ena_reg <= rd_ena_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign o_rd_ena  = rd_ena_reg;
  assign o_rd_addr = cnt_value;
  assign o_data    = data_reg;
  assign o_valid   = valid_reg;
  assign o_busy    = busy_reg;
  assign o_done    = done_reg;

endmodule

// File: tb/tb_ram_readout_ctrl.sv
// Scoreboard bench for ram_readout_ctrl with a 4-word BRAM model and randomized handshakes.
module tb_ram_readout_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic              o_rd_ena;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_busy;
  logic              o_done;

  always #5 clk = ~clk;

  ram_readout_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .o_rd_ena  (o_rd_ena),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // BRAM model: one-cycle registered read
  logic [DATA_W-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (o_rd_ena) i_rd_data <= mem[o_rd_addr];
  end

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   prev_valid = 0, prev_acc = 0, pending_done = 0;
  logic [DATA_W-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A dump always returns every word of memory in address order, last one flagged
  task automatic push_dump();
    for (int i = 0; i < WORDS; i++) exp_q.push_back('{d: mem[i], last: (i == WORDS - 1)});
  endtask

  // Monitor: pops on every accepted word and checks hold-stability and the done pulse
  always @(negedge clk) begin
    if (!i_rst_n) begin
      prev_valid   = 0;
      prev_acc     = 0;
      pending_done = 0;
    end else begin
      if (pending_done) begin
        chk("done_pulse", {31'd0, o_done}, 32'd1);
        pending_done = 0;
      end else if (o_done) begin
        chk("spurious_done", {31'd0, o_done}, 32'd0);
      end
      if (o_valid && o_rd_ena) chk("rd_ena_while_valid", {31'd0, o_rd_ena}, 32'd0);
      if (prev_valid && !prev_acc) begin
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_data", {24'd0, o_data}, {24'd0, prev_data});
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", {24'd0, o_data}, {24'd0, mon_e.d});
          if (mon_e.last) pending_done = 1;
        end
      end
      prev_valid = o_valid;
      prev_acc   = o_valid && i_ready;
      prev_data  = o_data;
    end
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    exp_q.delete();
    tick();
    chk("rst_rd_ena", {31'd0, o_rd_ena}, 32'd0);
    chk("rst_rd_addr", {30'd0, o_rd_addr}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("valid_timeout");
  endtask

  task automatic run_until_done(input bit rnd_ready, input bit rnd_start);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_start && k > 0) i_start = 1'($urandom_range(0, 1));
      tick();
      if (o_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = 8'hA0 + 8'(i);
    tick();
    do_reset();

    // Ready while idle is ignored
    i_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
    end

    // Full-rate dump: first valid 3 cycles after start, one word per 3 cycles
    i_start = 1'b1;
    push_dump();
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("valid_timing", {31'd0, o_valid}, {31'd0, (t % 3 == 0) && (t <= 12)});
      chk("done_timing", {31'd0, o_done}, {31'd0, t == 13});
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("done_hold_rd", {31'd0, o_rd_ena}, 32'd0);
      chk("done_hold_busy", {31'd0, o_busy}, 32'd1);
      chk("done_hold_valid", {31'd0, o_valid}, 32'd0);
    end
    i_start = 1'b0;
    tick();
    chk("done_exit_busy", {31'd0, o_busy}, 32'd0);
    tick();

    // Restart from address 0, drop start after the first word, stall on the second
    i_ready = 1'b0;
    i_start = 1'b1;
    push_dump();
    wait_valid();
    i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    i_ready = 1'b0;
    wait_valid();
    chk("stall_word", {24'd0, o_data}, {24'd0, mem[1]});
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_data", {24'd0, o_data}, {24'd0, mem[1]});
      chk("stall_rd_ena", {31'd0, o_rd_ena}, 32'd0);
    end
    run_until_done(0, 0);
    tick();
    tick();

    // Reset while presenting address 2, then a fresh dump
    i_ready = 1'b0;
    i_start = 1'b1;
    push_dump();
    for (int w = 0; w < 2; w++) begin
      wait_valid();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end
    wait_valid();
    chk("addr_before_reset", {30'd0, o_rd_addr}, 32'd2);
    do_reset();
    i_start = 1'b1;
    push_dump();
    run_until_done(1, 0);
    i_start = 1'b0;
    tick();
    tick();

    // Randomized dumps with random contents, handshakes and start levels
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < WORDS; i++) mem[i] = 8'($urandom_range(0, 255));
      i_start = 1'b1;
      push_dump();
      run_until_done(1, 1);
      i_start = 1'b1;
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        tick();
        chk("rand_done_rd", {31'd0, o_rd_ena}, 32'd0);
      end
      i_start = 1'b0;
      tick();
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        i_ready = 1'($urandom_range(0, 1));
        tick();
        chk("rand_idle_valid", {31'd0, o_valid}, 32'd0);
      end
    end

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
